// File: rtl/fetchflare_pref_pkg.sv
// fetchflare_pref_pkg: shared defaults, line/request types and slot states for the prefetch issue stage
package fetchflare_pref_pkg;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_ADDR_WIDTH = 40;
  localparam int DEF_LINE_OFFSET = 6;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_SRC_WIDTH = $clog2(DEF_NUM_SRC);
  typedef logic [DEF_ADDR_WIDTH-DEF_LINE_OFFSET-1:0] line_addr_t;
  typedef struct packed {
    line_addr_t addr;
    logic [DEF_SRC_WIDTH-1:0] src;
  } pref_req_t;
  typedef enum logic {EMPTY, HELD} slot_state_t;
endpackage

// File: rtl/fetchflare_pref_issue_if.sv
// fetchflare_pref_issue_if: source/arbiter/memory bundle of the prefetch issue stage
// FETCHFLARE_PREF_DUP_FILTER_EN adds the duplicate-drop counter.
interface fetchflare_pref_issue_if import fetchflare_pref_pkg::*; #(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
);
  logic [NUM_SRC-1:0] src_valid_i;
  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i;
  logic [NUM_SRC-1:0] src_ready_o;
  logic [NUM_SRC-1:0] arb_request_o;
  logic [NUM_SRC-1:0] arb_grant_i;
  logic arb_any_grant_i;
  logic mem_req_valid_o;
  logic [ADDR_WIDTH-1:0] mem_req_addr_o;
  logic [$clog2(NUM_SRC)-1:0] mem_req_src_o;
  logic mem_req_ready_i;
  logic mem_resp_valid_i;
  logic flush_i;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o;
`ifdef FETCHFLARE_PREF_DUP_FILTER_EN
  logic [15:0] dup_drop_cnt_o;
`endif
  modport slave (
    input src_valid_i, src_addr_i, arb_grant_i, arb_any_grant_i,
    input mem_req_ready_i, mem_resp_valid_i, flush_i,
    output
`ifdef FETCHFLARE_PREF_DUP_FILTER_EN
    dup_drop_cnt_o,
`endif
    src_ready_o, arb_request_o, mem_req_valid_o, mem_req_addr_o, mem_req_src_o, outstanding_o
  );
  modport master (
    output src_valid_i, src_addr_i, arb_grant_i, arb_any_grant_i,
    output mem_req_ready_i, mem_resp_valid_i, flush_i,
    input
`ifdef FETCHFLARE_PREF_DUP_FILTER_EN
    dup_drop_cnt_o,
`endif
    src_ready_o, arb_request_o, mem_req_valid_o, mem_req_addr_o, mem_req_src_o, outstanding_o
  );
endinterface

// File: rtl/fetchflare_onehot_enc.sv
// fetchflare_onehot_enc: one-hot grant to binary index encoder (zero input gives index 0)
module fetchflare_onehot_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = idx | (onehot[i] ? W'(i) : '0);
  end
endmodule

// File: rtl/fetchflare_pref_issue.sv
// fetchflare_pref_issue: credit-capped capture of arbiter-granted prefetches into one issue register
// FETCHFLARE_PREF_DUP_FILTER_EN drops grants that repeat the held or last-issued line.
module fetchflare_pref_issue import fetchflare_pref_pkg::*; #(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_OFFSET = DEF_LINE_OFFSET,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input logic clk,
  input logic reset,
  fetchflare_pref_issue_if.slave bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int LW = ADDR_WIDTH - LINE_OFFSET;
  slot_state_t state, state_n;
  logic [LW-1:0] held_line, grant_line;
  logic [SW-1:0] held_src, grant_src;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW:0] add_v;
  logic [1:0] sub_v;
  logic slot_free, credit_ok, can_accept, consume, capture, issue, dup, resp_credit, flush_credit;

  fetchflare_onehot_enc #(.N(NUM_SRC), .W(SW)) u_enc (.onehot(bus.arb_grant_i), .idx(grant_src));

  assign slot_free = state == EMPTY || bus.mem_req_ready_i;
  assign credit_ok = outstanding < CW'(MAX_OUTSTANDING);
  assign can_accept = slot_free && credit_ok && !bus.flush_i;
  assign consume = can_accept && bus.arb_any_grant_i;
  assign capture = consume && !dup;
  assign issue = state == HELD && bus.mem_req_ready_i;
  assign grant_addr = bus.src_addr_i[grant_src*ADDR_WIDTH +: ADDR_WIDTH];
  assign grant_line = LW'(grant_addr >> LINE_OFFSET);
  assign bus.arb_request_o = bus.src_valid_i & {NUM_SRC{can_accept}};
  assign bus.src_ready_o = consume ? bus.arb_grant_i : '0;
  assign bus.mem_req_valid_o = state == HELD;
  assign bus.mem_req_addr_o = {held_line, {LINE_OFFSET{1'b0}}};
  assign bus.mem_req_src_o = held_src;
  assign bus.outstanding_o = outstanding;
  // a flushed request that memory accepts in the same cycle is in flight and keeps its credit
  assign resp_credit = bus.mem_resp_valid_i && outstanding != '0;
  assign flush_credit = bus.flush_i && state == HELD && !bus.mem_req_ready_i;

  always_comb begin
    state_n = state;
    state_n = bus.flush_i ? EMPTY : capture ? HELD : issue ? EMPTY : state;
  end

  always_comb begin
    add_v = {1'b0, outstanding} + (CW+1)'(capture);
    sub_v = {1'b0, resp_credit} + {1'b0, flush_credit};
    outstanding_n = add_v > (CW+1)'(sub_v) ? CW'(add_v - (CW+1)'(sub_v)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_line <= '0;
      held_src <= '0;
      outstanding <= '0;
    end else begin
      if (capture) begin
        held_line <= grant_line;
        held_src <= grant_src;
      end
      outstanding <= outstanding_n;
    end
  end

`ifdef FETCHFLARE_PREF_DUP_FILTER_EN
  logic [LW-1:0] last_line;
  logic last_vld;
  logic [15:0] dup_cnt;
  assign dup = (state == HELD && grant_line == held_line) || (last_vld && grant_line == last_line);
  assign bus.dup_drop_cnt_o = dup_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.flush_i) begin
      last_line <= '0;
      last_vld <= 1'b0;
    end else if (issue) begin
      last_line <= held_line;
      last_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dup_cnt <= '0;
    else if (consume && dup && dup_cnt != '1) dup_cnt <= dup_cnt + 16'd1;
  end
`else
  assign dup = 1'b0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.arb_grant_i));
  a_grant_subset: assert property (@(posedge clk) disable iff (reset) (bus.arb_grant_i & ~bus.arb_request_o) == '0);
  a_any_grant: assert property (@(posedge clk) disable iff (reset) bus.arb_any_grant_i == |bus.arb_grant_i);
  a_resp_underflow: assert property (@(posedge clk) disable iff (reset) !(bus.mem_resp_valid_i && outstanding == '0));
endmodule

// File: tb/tb_fetchflare_pref_issue.sv
// tb_fetchflare_pref_issue: directed checks of the prefetch issue stage with a round-robin arbiter model
module tb_fetchflare_pref_issue;
  logic clk, rst;
  logic [1:0] ptr;
  int checks = 0;
  int errors = 0;

  fetchflare_pref_issue_if #(.NUM_SRC(4), .ADDR_WIDTH(40), .MAX_OUTSTANDING(8)) b();
  fetchflare_pref_issue_if #(.NUM_SRC(4), .ADDR_WIDTH(40), .MAX_OUTSTANDING(2)) b2();

  fetchflare_pref_issue #(.NUM_SRC(4), .ADDR_WIDTH(40), .LINE_OFFSET(6), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .reset(rst), .bus(b.slave));
  fetchflare_pref_issue #(.NUM_SRC(4), .ADDR_WIDTH(40), .LINE_OFFSET(6), .MAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .reset(rst), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rr(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] i;
    for (int k = 0; k < 4; k++) begin
      i = p + 2'(k);
      if (req[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    return g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
  endfunction

  always_comb b.arb_grant_i = rr(b.arb_request_o, ptr);
  assign b.arb_any_grant_i = |b.arb_grant_i;
  assign b2.arb_grant_i = b2.arb_request_o & (~b2.arb_request_o + 4'd1);
  assign b2.arb_any_grant_i = |b2.arb_grant_i;

  always @(posedge clk)
    if (rst) ptr <= 2'd0;
    else if (b.arb_any_grant_i) ptr <= enc(b.arb_grant_i) + 2'd1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    b.src_valid_i = '0; b.src_addr_i = '0; b.mem_req_ready_i = 0; b.mem_resp_valid_i = 0; b.flush_i = 0;
    b2.src_valid_i = '0; b2.src_addr_i = '0; b2.mem_req_ready_i = 0; b2.mem_resp_valid_i = 0; b2.flush_i = 0;
    tick;
    tick;
    chk("rst_valid", b.mem_req_valid_o, 0);
    chk("rst_addr", b.mem_req_addr_o, 0);
    chk("rst_src", b.mem_req_src_o, 0);
    chk("rst_outstanding", b.outstanding_o, 0);
`ifdef FETCHFLARE_PREF_DUP_FILTER_EN
    chk("rst_dup_cnt", b.dup_drop_cnt_o, 0);
`endif
    rst = 1'b0;
    // single source 2
    b.src_valid_i = 4'b0100;
    b.src_addr_i[80 +: 40] = 40'h1234;
    b.mem_req_ready_i = 1;
    #1;
    chk("single_request", b.arb_request_o, 4'b0100);
    chk("single_ready", b.src_ready_o, 4'b0100);
    tick;
    b.src_valid_i = '0;
    chk("single_valid", b.mem_req_valid_o, 1);
    chk("single_addr", b.mem_req_addr_o, 40'h1200);
    chk("single_src", b.mem_req_src_o, 2);
    chk("single_outstanding", b.outstanding_o, 1);
    b.mem_resp_valid_i = 1;
    tick;
    b.mem_resp_valid_i = 0;
    chk("drain_valid", b.mem_req_valid_o, 0);
    chk("drain_outstanding", b.outstanding_o, 0);
    // stall: all sources valid, memory not ready
    for (int n = 0; n < 4; n++) b.src_addr_i[n*40 +: 40] = 40'h1000 * (n + 1) + 40'h3f;
    b.src_valid_i = 4'b1111;
    b.mem_req_ready_i = 0;
    #1;
    chk("stall_request_empty", b.arb_request_o, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("stall_src", b.mem_req_src_o, 3);
      chk("stall_addr", b.mem_req_addr_o, 40'h4000);
      chk("stall_request_held", b.arb_request_o, 0);
      chk("stall_outstanding", b.outstanding_o, 1);
    end
    b.mem_req_ready_i = 1;
    #1;
    chk("release_ready", b.src_ready_o, 4'b0001);
    tick;
    chk("release_src", b.mem_req_src_o, 0);
    chk("release_addr", b.mem_req_addr_o, 40'h1000);
    chk("release_outstanding", b.outstanding_o, 2);
    // rotation with a response every cycle
    b.mem_resp_valid_i = 1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk("rot_valid", b.mem_req_valid_o, 1);
      chk("rot_src", b.mem_req_src_o, 64'(c % 4));
      chk("rot_outstanding", b.outstanding_o, 2);
    end
    b.mem_resp_valid_i = 0;
    tick;
    chk("pre_flush_src", b.mem_req_src_o, 1);
    chk("pre_flush_outstanding", b.outstanding_o, 3);
    b.mem_req_ready_i = 0;
    b.flush_i = 1;
    #1;
    chk("flush_request", b.arb_request_o, 0);
    chk("flush_ready", b.src_ready_o, 0);
    tick;
    b.flush_i = 0;
    chk("flush_valid", b.mem_req_valid_o, 0);
    chk("flush_outstanding", b.outstanding_o, 2);
    b.mem_req_ready_i = 1;
    tick;
    chk("mid_valid", b.mem_req_valid_o, 1);
    chk("mid_src", b.mem_req_src_o, 2);
    chk("mid_outstanding", b.outstanding_o, 3);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    b.src_valid_i = '0;
    chk("midrst_valid", b.mem_req_valid_o, 0);
    chk("midrst_addr", b.mem_req_addr_o, 0);
    chk("midrst_src", b.mem_req_src_o, 0);
    chk("midrst_outstanding", b.outstanding_o, 0);
    // credit cap on the MAX_OUTSTANDING=2 instance
    b2.src_valid_i = 4'b0001;
    b2.src_addr_i[0 +: 40] = 40'h80;
    b2.mem_req_ready_i = 1;
    tick;
    chk("cap_first", b2.outstanding_o, 1);
    tick;
    chk("cap_second", b2.outstanding_o, 2);
    chk("cap_addr", b2.mem_req_addr_o, 40'h80);
    chk("cap_request_blocked", b2.arb_request_o, 0);
    tick;
    chk("cap_idle_valid", b2.mem_req_valid_o, 0);
    chk("cap_idle_outstanding", b2.outstanding_o, 2);
    b2.mem_resp_valid_i = 1;
    #1;
    chk("cap_no_bypass", b2.arb_request_o, 0);
    tick;
    b2.mem_resp_valid_i = 0;
    chk("cap_credit_back", b2.outstanding_o, 1);
    chk("cap_resume", b2.arb_request_o, 4'b0001);
    tick;
    chk("cap_refill", b2.outstanding_o, 2);
    chk("cap_refill_valid", b2.mem_req_valid_o, 1);
    b2.src_valid_i = '0;
`ifdef FETCHFLARE_PREF_DUP_FILTER_EN
    b.src_addr_i = '0;
    b.src_addr_i[0 +: 40] = 40'h1240;
    b.src_addr_i[40 +: 40] = 40'h1240;
    b.src_valid_i = 4'b0001;
    b.mem_req_ready_i = 1;
    tick;
    chk("dup_first_addr", b.mem_req_addr_o, 40'h1240);
    b.src_valid_i = 4'b0010;
    #1;
    chk("dup_consumed", b.src_ready_o, 4'b0010);
    tick;
    b.src_valid_i = '0;
    chk("dup_not_issued", b.mem_req_valid_o, 0);
    chk("dup_cnt", b.dup_drop_cnt_o, 1);
    chk("dup_outstanding", b.outstanding_o, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
